// File: rtl/anita4_trig_pulse_tx_if.sv
// Signal bundle between a trigger source/housekeeping host and the ANITA4 trigger-line transmitter.
interface anita4_trig_pulse_tx_if #(
    parameter int WIDTH_BITS   = 4,
    parameter int HOLDOFF_BITS = 8,
    parameter int SCALER_BITS  = 16
);
    logic                    TRIG_REQ;
    logic                    MASK;
    logic                    FORCE;
    logic [WIDTH_BITS-1:0]   PULSE_WIDTH;
    logic [HOLDOFF_BITS-1:0] HOLDOFF;
    logic                    SCALER_CLR;
    logic                    TRIG_OUT;
    logic                    BUSY;
    logic [SCALER_BITS-1:0]  SCALER;
    logic [SCALER_BITS-1:0]  DROPPED;

    modport master (
        output TRIG_REQ, MASK, FORCE, PULSE_WIDTH, HOLDOFF, SCALER_CLR,
        input  TRIG_OUT, BUSY, SCALER, DROPPED
    );

    modport slave (
        input  TRIG_REQ, MASK, FORCE, PULSE_WIDTH, HOLDOFF, SCALER_CLR,
        output TRIG_OUT, BUSY, SCALER, DROPPED
    );
endinterface

// File: rtl/anita4_trig_pulse_tx.sv
// Trigger-line transmitter: turns request edges into an active-low pulse of programmable
// width followed by a hold-off window, with saturating accept/drop counters.
module anita4_trig_pulse_tx #(
    parameter int WIDTH_BITS   = 4,
    parameter int HOLDOFF_BITS = 8,
    parameter int SCALER_BITS  = 16
) (
    input  logic                    CLK,
    input  logic                    CLR_N,
    anita4_trig_pulse_tx_if.slave   bus
);
    localparam int CW = (WIDTH_BITS > HOLDOFF_BITS) ? WIDTH_BITS : HOLDOFF_BITS;
    localparam logic [CW-1:0]           CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]           CNT_ONE    = CW'(1);
    localparam logic [WIDTH_BITS-1:0]   PW_ZERO    = {WIDTH_BITS{1'b0}};
    localparam logic [HOLDOFF_BITS-1:0] HO_ZERO    = {HOLDOFF_BITS{1'b0}};
    localparam logic [SCALER_BITS-1:0]  SC_ZERO    = {SCALER_BITS{1'b0}};
    localparam logic [SCALER_BITS-1:0]  SC_ONE     = SCALER_BITS'(1);
    localparam logic [SCALER_BITS-1:0]  SC_MAX     = {SCALER_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CW-1:0]           cnt_r;
    logic [HOLDOFF_BITS-1:0] holdoff_r;
    logic                    req_d_r;
    logic                    force_d_r;
    logic                    trig_out_r;
    logic                    busy_r;
    logic [SCALER_BITS-1:0]  scaler_r;
    logic [SCALER_BITS-1:0]  dropped_r;

    logic                    go_s;
    logic                    accept_s;
    logic                    drop_s;

    function automatic logic [SCALER_BITS-1:0] sat_inc(input logic [SCALER_BITS-1:0] v);
        if (v == SC_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + SC_ONE;
        end
    endfunction

    // Request qualification: MASK gates only the hardware request, FORCE always counts
    always_comb begin
        go_s     = (bus.TRIG_REQ & ~req_d_r & ~bus.MASK) | (bus.FORCE & ~force_d_r);
        accept_s = go_s & (state_r == ST_IDLE);
        drop_s   = go_s & (state_r != ST_IDLE);
    end

    // Line FSM, edge-detect history and housekeeping counters
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            holdoff_r  <= HO_ZERO;
            req_d_r    <= 1'b1;
            force_d_r  <= 1'b1;
            trig_out_r <= 1'b1;
            busy_r     <= 1'b0;
            scaler_r   <= SC_ZERO;
            dropped_r  <= SC_ZERO;
        end else begin
            req_d_r   <= bus.TRIG_REQ;
            force_d_r <= bus.FORCE;

            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        state_r    <= ST_PULSE;
                        trig_out_r <= 1'b0;
                        busy_r     <= 1'b1;
                        holdoff_r  <= bus.HOLDOFF;
                        if (bus.PULSE_WIDTH == PW_ZERO) begin
                            cnt_r <= CNT_ZERO;
                        end else begin
                            cnt_r <= CW'(bus.PULSE_WIDTH) - CNT_ONE;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        trig_out_r <= 1'b1;
                        if (holdoff_r != HO_ZERO) begin
                            state_r <= ST_HOLD;
                            cnt_r   <= CW'(holdoff_r) - CNT_ONE;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    trig_out_r <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase

            // A clear coinciding with an event leaves that event counted once
            if (accept_s) begin
                scaler_r  <= bus.SCALER_CLR ? SC_ONE : sat_inc(scaler_r);
                dropped_r <= bus.SCALER_CLR ? SC_ZERO : dropped_r;
            end else if (drop_s) begin
                dropped_r <= bus.SCALER_CLR ? SC_ONE : sat_inc(dropped_r);
                scaler_r  <= bus.SCALER_CLR ? SC_ZERO : scaler_r;
            end else if (bus.SCALER_CLR) begin
                scaler_r  <= SC_ZERO;
                dropped_r <= SC_ZERO;
            end
        end
    end

    assign bus.TRIG_OUT = trig_out_r;
    assign bus.BUSY     = busy_r;
    assign bus.SCALER   = scaler_r;
    assign bus.DROPPED  = dropped_r;
endmodule

// File: tb/tb_anita4_trig_pulse_tx.sv
// Directed bench for the ANITA4 trigger-line transmitter with hand-derived expectations.
module tb_anita4_trig_pulse_tx;
    localparam int SB = 10;
    localparam logic [31:0] SMAX = (32'd1 << SB) - 32'd1;

    logic CLK;
    logic CLR_N;
    int   n_checks;
    int   n_errors;

    anita4_trig_pulse_tx_if #(.WIDTH_BITS(4), .HOLDOFF_BITS(8), .SCALER_BITS(SB)) bus ();

    anita4_trig_pulse_tx #(.WIDTH_BITS(4), .HOLDOFF_BITS(8), .SCALER_BITS(SB)) dut (
        .CLK   (CLK),
        .CLR_N (CLR_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [6:0] rv;
    logic [6:0] fv;

    initial begin
        n_checks = 0;
        n_errors = 0;
        CLR_N           = 1'b0;
        bus.TRIG_REQ    = 1'b1;
        bus.MASK        = 1'b0;
        bus.FORCE       = 1'b0;
        bus.PULSE_WIDTH = 4'd3;
        bus.HOLDOFF     = 8'd2;
        bus.SCALER_CLR  = 1'b0;

        // Reset with request already high: nothing fires after release
        tick();
        tick();
        chk("rst_trig", {31'd0, bus.TRIG_OUT}, 32'd1);
        chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        chk("rst_scaler", 32'(bus.SCALER), 32'd0);
        chk("rst_dropped", 32'(bus.DROPPED), 32'd0);
        CLR_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_high_trig", {31'd0, bus.TRIG_OUT}, 32'd1);
        end
        chk("idle_high_scaler", 32'(bus.SCALER), 32'd0);
        bus.TRIG_REQ = 1'b0;
        tick();

        // Basic pulse W=3, HOLDOFF=2
        bus.TRIG_REQ = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("basic_trig", {31'd0, bus.TRIG_OUT}, (k < 3) ? 32'd0 : 32'd1);
            chk("basic_busy", {31'd0, bus.BUSY}, (k < 5) ? 32'd1 : 32'd0);
        end
        chk("basic_scaler", 32'(bus.SCALER), 32'd1);
        bus.TRIG_REQ = 1'b0;
        bus.SCALER_CLR = 1'b1;
        tick();
        bus.SCALER_CLR = 1'b0;
        chk("clr_scaler", 32'(bus.SCALER), 32'd0);

        // Hold-off drops: edges at N, N+2, N+5 (FORCE), N+6
        rv = 7'b1000101;
        fv = 7'b0100000;
        for (int k = 0; k < 7; k++) begin
            bus.TRIG_REQ = rv[k];
            bus.FORCE    = fv[k];
            tick();
        end
        chk("drop_scaler", 32'(bus.SCALER), 32'd2);
        chk("drop_dropped", 32'(bus.DROPPED), 32'd2);
        chk("drop_reaccept_trig", {31'd0, bus.TRIG_OUT}, 32'd0);
        bus.TRIG_REQ = 1'b0;
        bus.FORCE    = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("drop_idle_busy", {31'd0, bus.BUSY}, 32'd0);

        // Masked request ignored; FORCE fires under mask; width 0 gives one low cycle
        bus.MASK = 1'b1;
        bus.PULSE_WIDTH = 4'd0;
        bus.HOLDOFF = 8'd0;
        bus.TRIG_REQ = 1'b1;
        tick();
        chk("mask_trig", {31'd0, bus.TRIG_OUT}, 32'd1);
        chk("mask_busy", {31'd0, bus.BUSY}, 32'd0);
        tick();
        chk("mask_scaler", 32'(bus.SCALER), 32'd2);
        chk("mask_dropped", 32'(bus.DROPPED), 32'd2);
        bus.FORCE = 1'b1;
        tick();
        chk("force_trig_low", {31'd0, bus.TRIG_OUT}, 32'd0);
        chk("force_scaler", 32'(bus.SCALER), 32'd3);
        tick();
        chk("w0_trig_high", {31'd0, bus.TRIG_OUT}, 32'd1);
        chk("w0_busy", {31'd0, bus.BUSY}, 32'd0);
        bus.FORCE = 1'b0;
        bus.MASK = 1'b0;
        bus.TRIG_REQ = 1'b0;
        bus.SCALER_CLR = 1'b1;
        tick();
        bus.SCALER_CLR = 1'b0;

        // Scaler saturation with W=1, HOLDOFF=0: one accept every two cycles
        bus.PULSE_WIDTH = 4'd1;
        for (int i = 0; i < int'(SMAX); i++) begin
            bus.TRIG_REQ = 1'b1;
            tick();
            bus.TRIG_REQ = 1'b0;
            tick();
        end
        chk("sat_full", 32'(bus.SCALER), SMAX);
        chk("sat_no_drops", 32'(bus.DROPPED), 32'd0);
        bus.TRIG_REQ = 1'b1;
        tick();
        bus.TRIG_REQ = 1'b0;
        tick();
        chk("sat_hold", 32'(bus.SCALER), SMAX);
        bus.TRIG_REQ = 1'b1;
        bus.SCALER_CLR = 1'b1;
        tick();
        chk("clr_accept_scaler", 32'(bus.SCALER), 32'd1);
        chk("clr_accept_dropped", 32'(bus.DROPPED), 32'd0);
        bus.SCALER_CLR = 1'b0;
        bus.TRIG_REQ = 1'b0;
        tick();

        // Drop together with clear
        bus.PULSE_WIDTH = 4'd4;
        bus.TRIG_REQ = 1'b1;
        tick();
        chk("pre_drop_scaler", 32'(bus.SCALER), 32'd2);
        bus.TRIG_REQ = 1'b0;
        tick();
        bus.TRIG_REQ = 1'b1;
        bus.SCALER_CLR = 1'b1;
        tick();
        chk("clr_drop_dropped", 32'(bus.DROPPED), 32'd1);
        chk("clr_drop_scaler", 32'(bus.SCALER), 32'd0);
        bus.SCALER_CLR = 1'b0;
        bus.TRIG_REQ = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // Dropped counter saturation under long pulses and hold-off
        bus.PULSE_WIDTH = 4'd15;
        bus.HOLDOFF = 8'd255;
        for (int i = 0; i < 3000; i++) begin
            bus.TRIG_REQ = ~bus.TRIG_REQ;
            tick();
        end
        chk("drop_sat", 32'(bus.DROPPED), SMAX);
        bus.TRIG_REQ = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        chk("drop_sat_idle", {31'd0, bus.BUSY}, 32'd0);

        // Reset mid-pulse with W=8
        bus.PULSE_WIDTH = 4'd8;
        bus.HOLDOFF = 8'd0;
        bus.TRIG_REQ = 1'b1;
        tick();
        chk("mid_low", {31'd0, bus.TRIG_OUT}, 32'd0);
        tick();
        CLR_N = 1'b0;
        #1;
        chk("mid_async_trig", {31'd0, bus.TRIG_OUT}, 32'd1);
        chk("mid_async_busy", {31'd0, bus.BUSY}, 32'd0);
        tick();
        #1;
        CLR_N = 1'b1;
        tick();
        chk("mid_release_trig", {31'd0, bus.TRIG_OUT}, 32'd1);
        bus.TRIG_REQ = 1'b0;
        tick();
        bus.TRIG_REQ = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("mid_full_pulse", {31'd0, bus.TRIG_OUT}, (k < 8) ? 32'd0 : 32'd1);
        end
        chk("mid_scaler", 32'(bus.SCALER), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
